// File: rtl/gpr_file.sv
// -----------------------------------------------------------------------------
// gpr_file
//   Architectural register file serving the decode stage.
//   - NUM_REGS x DATA_W general-purpose registers; register 0 reads as zero and
//     ignores writes.
//   - HI/LO register pair, written together.
//   - Read ports 1 and 2 are combinational and bypass the write port, so a value
//     written in cycle N is visible to decode in cycle N.
//   - The debug port reads storage only (no bypass).
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset; forces every output to 0
//   we         in   GPR write enable (MEM/WB)
//   waddr      in   GPR write address
//   wdata      in   GPR write data
//   re1/re2    in   read-port enables (decode)
//   raddr1/2   in   read-port addresses
//   rdata1/2   out  read-port data (combinational, bypassed)
//   hilo_we    in   HI/LO write enable
//   hi_i/lo_i  in   HI/LO write data
//   hi_o/lo_o  out  HI/LO read data (combinational, bypassed)
//   dbg_raddr  in   debug read address
//   dbg_rdata  out  debug read data (storage only)
// -----------------------------------------------------------------------------
module gpr_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              hilo_we,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    input  logic [ADDR_W-1:0] dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    // NOTE: every entry is cleared on reset because software may read any
    // register straight after reset and must see 0; this forces the array into
    // flops rather than a RAM macro, which is acceptable at 32 entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from the
            // pre-edge values, so ordering inside this block does not matter.
            if (we && (waddr != '0)) begin
                regs[waddr] <= wdata;
            end
            if (hilo_we) begin
                hi_q <= hi_i;
                lo_q <= lo_i;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Decode read ports: reset, enable, r0, bypass, storage -- in that priority.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: each output gets a default before any condition so no path
        // leaves it unassigned, which would infer a latch.
        rdata1 = '0;
        if (!rst && re1 && (raddr1 != '0)) begin
            if (we && (waddr == raddr1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (!rst && re2 && (raddr2 != '0)) begin
            if (we && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs[raddr2];
            end
        end
    end

    // -------------------------------------------------------------------------
    // HI/LO read, bypassed from the HI/LO write port.
    // -------------------------------------------------------------------------
    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (!rst) begin
            hi_o = hilo_we ? hi_i : hi_q;
            lo_o = hilo_we ? lo_i : lo_q;
        end
    end

    // -------------------------------------------------------------------------
    // Debug read: storage only, so it shows the pre-write value during a write.
    // -------------------------------------------------------------------------
    always_comb begin
        dbg_rdata = '0;
        if (!rst && (dbg_raddr != '0)) begin
            dbg_rdata = regs[dbg_raddr];
        end
    end

endmodule
